// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port data-memory port
// shared by the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_lock;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_gnt, b_rvalid, b_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_gnt, b_rvalid, b_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: alternating tie-break, B bus lock with a
// starvation guard for A, and one-cycle read-data return per requester.
//
// state  | meaning
// ARB    | normal arbitration, tie goes to the requester that did not win last
// LOCK_B | B holds the bus; A is blocked until lock drops or A has waited 16 cycles
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input logic          CLK,
  input logic          RSTn,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCK_B} state_t;

  state_t        state;
  logic          last_b;
  logic [4:0]    starve_cnt;
  logic          a_gnt_c;
  logic          b_gnt_c;
  logic          a_rvalid_q;
  logic          b_rvalid_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic          m_we_c;
  logic [AW-1:0] m_addr_c;
  logic [DW-1:0] m_wdata_c;

  // Grants are gated by RSTn so nothing reaches the memory while in reset.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (RSTn) begin
      if (state == LOCK_B) begin
        b_gnt_c = bus.b_req;
      end else if (bus.a_req && bus.b_req) begin
        a_gnt_c = last_b;
        b_gnt_c = ~last_b;
      end else begin
        a_gnt_c = bus.a_req;
        b_gnt_c = bus.b_req;
      end
    end
  end

  always_comb begin
    m_we_c    = 1'b0;
    m_addr_c  = '0;
    m_wdata_c = '0;
    if (a_gnt_c) begin
      m_we_c    = bus.a_we;
      m_addr_c  = bus.a_addr;
      m_wdata_c = bus.a_wdata;
    end else if (b_gnt_c) begin
      m_we_c    = bus.b_we;
      m_addr_c  = bus.b_addr;
      m_wdata_c = bus.b_wdata;
    end
  end

  assign bus.a_gnt    = a_gnt_c;
  assign bus.b_gnt    = b_gnt_c;
  assign bus.m_en     = a_gnt_c | b_gnt_c;
  assign bus.m_we     = m_we_c;
  assign bus.m_addr   = m_addr_c;
  assign bus.m_wdata  = m_wdata_c;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  // Memory data is live only in the return cycle; the held copy covers the rest.
  assign bus.a_rdata  = a_rvalid_q ? bus.m_rdata : a_rdata_q;
  assign bus.b_rdata  = b_rvalid_q ? bus.m_rdata : b_rdata_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ARB;
      last_b     <= 1'b1;
      starve_cnt <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_gnt_c & ~bus.a_we;
      b_rvalid_q <= b_gnt_c & ~bus.b_we;
      if (a_rvalid_q) a_rdata_q <= bus.m_rdata;
      if (b_rvalid_q) b_rdata_q <= bus.m_rdata;

      if (a_gnt_c) last_b <= 1'b0;
      if (b_gnt_c) last_b <= 1'b1;

      case (state)
        ARB: begin
          if (b_gnt_c && bus.b_lock) begin
            state      <= LOCK_B;
            starve_cnt <= '0;
          end
        end
        LOCK_B: begin
          if (!bus.b_lock) begin
            state <= ARB;
          end else if (bus.a_req) begin
            // 16th consecutive blocked cycle for A: break the lock, A wins next tie.
            if (starve_cnt == 5'd15) begin
              state  <= ARB;
              last_b <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + 5'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a behavioural memory,
// a reference arbitration model and a read-return scoreboard.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural single-port memory; unread cycles put noise on m_rdata.
  logic [DW-1:0] mem [1024];
  bit            mem_wr [1024];
  always @(posedge CLK) begin
    if (bus.m_en && bus.m_we) begin
      mem[bus.m_addr]    <= bus.m_wdata;
      mem_wr[bus.m_addr] <= 1'b1;
    end
    if (bus.m_en && !bus.m_we)
      bus.m_rdata <= mem_wr[bus.m_addr] ? mem[bus.m_addr] : init_word(int'(bus.m_addr));
    else
      bus.m_rdata <= $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: who holds the bus and who wins the next tie.
  bit          locked;
  bit          prefer_a;
  int          lock_wait;
  logic [31:0] ref_mem [1024];
  bit          ref_wr [1024];

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] a_hold, b_hold;

  function automatic logic [31:0] ref_read(logic [9:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(int'(a));
  endfunction

  task automatic model_reset();
    locked = 0; prefer_a = 1; lock_wait = 0;
    qa.delete(); qb.delete();
    a_hold = '0; b_hold = '0;
  endtask

  logic        ar, aw, br, bw, bl;
  logic [9:0]  aa, ba;
  logic [31:0] ad, bd;
  bit          eg_a, eg_b, rst_pending;
  logic        s_a_gnt, s_b_gnt;
  logic [31:0] s_m_wdata;
  logic [9:0]  s_m_addr;

  task automatic step();
    bit ga, gb;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd; bus.b_lock = bl;
    @(negedge CLK);
    ga = 0; gb = 0;
    if (locked) gb = br;
    else if (ar && br) begin ga = prefer_a; gb = !prefer_a; end
    else begin ga = ar; gb = br; end
    e_we = 0; e_addr = '0; e_wdata = '0;
    if (ga) begin e_we = aw; e_addr = aa; e_wdata = ad; end
    if (gb) begin e_we = bw; e_addr = ba; e_wdata = bd; end
    s_a_gnt = bus.a_gnt; s_b_gnt = bus.b_gnt; s_m_addr = bus.m_addr; s_m_wdata = bus.m_wdata;
    chk("a_gnt", 32'(bus.a_gnt), 32'(ga));
    chk("b_gnt", 32'(bus.b_gnt), 32'(gb));
    chk("m_en", 32'(bus.m_en), 32'(ga | gb));
    chk("m_we", 32'(bus.m_we), 32'(e_we));
    chk("m_addr", 32'(bus.m_addr), 32'(e_addr));
    chk("m_wdata", bus.m_wdata, e_wdata);
    if ((ga || gb) && e_we) begin ref_mem[e_addr] = e_wdata; ref_wr[e_addr] = 1; end
    if (ga && !aw) qa.push_back('{cyc + 1, ref_read(aa)});
    if (gb && !bw) qb.push_back('{cyc + 1, ref_read(ba)});
    if (ga) prefer_a = 0;
    if (gb) prefer_a = 1;
    if (!locked) begin
      if (gb && bl) begin locked = 1; lock_wait = 0; end
    end else if (!bl) begin
      locked = 0;
    end else begin
      lock_wait = ar ? lock_wait + 1 : 0;
      if (lock_wait == 16) begin locked = 0; prefer_a = 1; end
    end
    eg_a = ga; eg_b = gb;
    if (rst_pending) begin RSTn = 1'b0; model_reset(); rst_pending = 0; end
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_gnt"}, 32'(bus.a_gnt), 32'd0);
    chk({tag, "_b_gnt"}, 32'(bus.b_gnt), 32'd0);
    chk({tag, "_m_en"}, 32'(bus.m_en), 32'd0);
    chk({tag, "_m_we"}, 32'(bus.m_we), 32'd0);
    chk({tag, "_m_addr"}, 32'(bus.m_addr), 32'd0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
    chk({tag, "_a_rvalid"}, 32'(bus.a_rvalid), 32'd0);
    chk({tag, "_b_rvalid"}, 32'(bus.b_rvalid), 32'd0);
    chk({tag, "_a_rdata"}, bus.a_rdata, 32'd0);
    chk({tag, "_b_rdata"}, bus.b_rdata, 32'd0);
  endtask

  // Read-return monitor: pops the scoreboard whenever a port presents rvalid.
  exp_t me;
  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      if (bus.a_rvalid) begin
        if (qa.size() == 0) chk("a_rvalid_unexpected", 32'(bus.a_rvalid), 32'd0);
        else begin
          me = qa.pop_front();
          chk("a_rvalid_time", 32'(cyc), 32'(me.due));
          chk("a_rdata", bus.a_rdata, me.data);
          a_hold = me.data;
        end
      end else begin
        if (qa.size() != 0 && qa[0].due <= cyc) begin
          qa.delete(0);
          chk("a_rvalid_missing", 32'(bus.a_rvalid), 32'd1);
        end
        chk("a_rdata_hold", bus.a_rdata, a_hold);
      end
      if (bus.b_rvalid) begin
        if (qb.size() == 0) chk("b_rvalid_unexpected", 32'(bus.b_rvalid), 32'd0);
        else begin
          me = qb.pop_front();
          chk("b_rvalid_time", 32'(cyc), 32'(me.due));
          chk("b_rdata", bus.b_rdata, me.data);
          b_hold = me.data;
        end
      end else begin
        if (qb.size() != 0 && qb[0].due <= cyc) begin
          qb.delete(0);
          chk("b_rvalid_missing", 32'(bus.b_rvalid), 32'd1);
        end
        chk("b_rdata_hold", bus.b_rdata, b_hold);
      end
    end
  end

  initial begin
    int first_a;
    ar = 0; aw = 0; aa = '0; ad = '0; br = 0; bw = 0; ba = '0; bd = '0; bl = 0;
    rst_pending = 0;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 10'h123; bus.a_wdata = 32'h1;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 10'h321; bus.b_wdata = 32'h2; bus.b_lock = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("por");
    @(posedge CLK); #1;
    RSTn = 1'b1;

    // Tie of two reads after reset alternates A,B,A,B.
    ar = 1; aw = 0; aa = 10'h004; ad = $urandom;
    br = 1; bw = 0; ba = 10'h010; bd = $urandom;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_alt_a_gnt", 32'(s_a_gnt), 32'((i % 2) == 0));
    end
    ar = 0; br = 0; step();

    ar = 1; aw = 1; aa = 10'h3FF; ad = 32'hDEADBEEF;
    step();
    chk("wr_m_addr", 32'(s_m_addr), 32'h3FF);
    chk("wr_m_wdata", s_m_wdata, 32'hDEADBEEF);
    ar = 0; step();

    ar = 1; aw = 0; aa = 10'h020;
    br = 1; bw = 1; ba = 10'h021; bd = $urandom; bl = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lock_b_gnt", 32'(s_b_gnt), 32'd1);
      chk("lock_a_blocked", 32'(s_a_gnt), 32'd0);
    end
    bl = 0; step();
    step();
    chk("unlock_tie_a", 32'(s_a_gnt), 32'd1);

    // Lock held long enough to trip the starvation guard.
    aa = 10'h040; bl = 1; first_a = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_a_gnt && first_a < 0) first_a = i;
    end
    chk("starve_first_a", 32'(first_a), 32'd17);
    ar = 0; br = 0; bl = 0; step();

    // Reset right after an A read grant drops the pending return.
    ar = 1; aw = 0; aa = 10'h055; rst_pending = 1;
    step();
    chk("pre_rst_a_gnt", 32'(s_a_gnt), 32'd1);
    ar = 1; br = 1; bw = 0; ba = 10'h066; bl = 1;
    bus.a_req = 1; bus.b_req = 1; bus.b_lock = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check_reset_outputs("midrst");
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    bl = 0;
    step();
    chk("post_rst_tie_a", 32'(s_a_gnt), 32'd1);
    ar = 0; br = 0; step();

    for (int i = 0; i < 600; i++) begin
      step();
      if (eg_a || !ar) begin
        ar = ($urandom_range(0, 3) != 0); aw = $urandom_range(0, 1);
        aa = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)); ad = $urandom;
      end
      if (eg_b || !br) begin
        br = ($urandom_range(0, 3) != 0); bw = $urandom_range(0, 1);
        ba = 10'($urandom_range(0, 15)); bd = $urandom;
      end
      if ($urandom_range(0, 11) == 0) bl = ~bl;
    end

    ar = 0; br = 0; bl = 0;
    repeat (3) step();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
